program_counter_stack: RTL and testbench
========================================

Name: program_counter_stack

Overview:
- Parametrised next-generation program counter for the CPU fetch stage.
- Generalises address width; adds stall, subroutine call/return with an on-chip return-address stack, and stack status/error flags.
- Output `address` drives instruction-memory fetch.
- Absolute jump and branch targets come from the decode/branch units.

Parameters:
- ADDR_W, 8, width of the program address and all target inputs.
- STACK_DEPTH, 4, number of return-address entries (>=1).
- RESET_ADDR, 0, value loaded into `address` on reset.
- TRAP_ADDR, {ADDR_W{1'b1}}, trap vector (used only with PC_TRAP_EN).

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- stall  input  1  hold PC and stack unchanged this cycle.
- jump  input  1  load `jump_adr`.
- jump_adr  input  ADDR_W  absolute jump target.
- branch  input  1  load `branch_adr` (branch already resolved taken).
- branch_adr  input  ADDR_W  absolute branch target.
- call  input  1  push return address, load `call_adr`.
- call_adr  input  ADDR_W  subroutine entry address.
- ret  input  1  pop return address into PC.
- address  output  ADDR_W  current program address (registered).
- stack_empty  output  1  stack holds 0 entries (combinational from count).
- stack_full  output  1  stack holds STACK_DEPTH entries.
- stack_ovf  output  1  sticky: call attempted while full.
- stack_unf  output  1  sticky: ret attempted while empty.

Behaviour:
- Reset (reset=0, asynchronous, any time, including mid-call or mid-stall):
  - `address`=RESET_ADDR, stack count=0, stack_ovf=0, stack_unf=0.
  - Therefore stack_empty=1, stack_full=0.
  - Stack entry contents are don't-care.
- All updates occur on the rising clk edge. One-cycle latency: a control asserted before edge N is visible on `address` after edge N.
- Per-edge priority, highest first; exactly one action per edge:
  1. stall: `address`, stack and flags all hold. Every other control is ignored.
  2. ret:
     - If not empty: `address` = top entry, count-1.
     - If empty: `address` = `address`+1, stack_unf<=1.
  3. call:
     - If not full: push (`address`+1) mod 2^ADDR_W, count+1, `address`=call_adr.
     - If full: no push, `address`=call_adr, stack_ovf<=1.
  4. jump: `address`=jump_adr.
  5. branch: `address`=branch_adr.
  6. Otherwise: `address`=(`address`+1) mod 2^ADDR_W. Wraps from all-ones to 0 with no flag.
- Simultaneous controls: a lower-priority control asserted with a higher one is discarded, not queued.
  - Example: call+jump performs the call only.
- Stack is LIFO. The return address pushed is the increment of the calling address, modulo wrap.
  - A call at all-ones pushes 0.
- stack_ovf and stack_unf are cleared only by reset. Once set they stay 1 through further activity.
- No internal state other than `address`, stack entries, count and the two sticky flags.

Optional Feature:
- Macro: PC_TRAP_EN.
- When defined:
  - Call while full: `address`=TRAP_ADDR instead of call_adr. Stack unchanged, stack_ovf<=1.
  - Ret while empty: `address`=TRAP_ADDR instead of `address`+1, stack_unf<=1.
- When undefined: behaviour exactly as in Behaviour. TRAP_ADDR is unused.

Test Plan:
- Reset then run (ADDR_W=8): hold reset=0 20 ns, release → `address`=0x00, then 0x01, 0x02, … one per clock; stack_empty=1.
- Jump/branch/wrap:
  - jump=1, jump_adr=0xFE for one clock → `address` 0xFE, 0xFF, 0x00, 0x01 (wrap, no flags).
  - branch=1, branch_adr=0x80 → 0x80 next cycle.
- Nested call/ret:
  - At 0x10 call 0x40 → 0x40; at 0x41 call 0x60 → 0x60, stack count 2.
  - ret → 0x42; ret → 0x11; stack_empty=1.
- Overflow/underflow (STACK_DEPTH=4):
  - 4 calls → stack_full=1. 5th call to 0x90 → `address`=0x90, stack_ovf=1, count stays 4.
  - After 4 rets, a 5th ret → `address` increments, stack_unf=1.
  - Both flags stay 1 until reset. With PC_TRAP_EN, both error cases give `address`=0xFF.
- Stall and priority:
  - stall=1 with call=1, jump=1 for 3 clocks → `address` and count unchanged.
  - Drop stall, assert call+jump+branch → call taken, return address pushed.
- Async reset mid-operation: assert reset=0 between edges while count=2 and stall=1 → `address`=0x00, count=0, flags 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/program_counter_stack.sv
// Program counter with stall, jump/branch and a LIFO return-address stack with sticky error flags.
// Optional build macro PC_TRAP_EN: stack overflow/underflow redirect the PC to TRAP_ADDR.
module program_counter_stack #(
   parameter int unsigned       ADDR_W      = 8,
   parameter int unsigned       STACK_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
   parameter logic [ADDR_W-1:0] TRAP_ADDR   = {ADDR_W{1'b1}}
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              jump,
   input  logic [ADDR_W-1:0] jump_adr,
   input  logic              branch,
   input  logic [ADDR_W-1:0] branch_adr,
   input  logic              call,
   input  logic [ADDR_W-1:0] call_adr,
   input  logic              ret,
   output logic [ADDR_W-1:0] address,
   output logic              stack_empty,
   output logic              stack_full,
   output logic              stack_ovf,
   output logic              stack_unf
);

   localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);
   localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

   logic [ADDR_W-1:0] addr_inc;
   logic [ADDR_W-1:0] ovf_addr;
   logic [ADDR_W-1:0] unf_addr;
   logic [IDX_W-1:0]  top_idx;
   logic [IDX_W-1:0]  push_idx;
   logic              push_en;
   logic              empty;
   logic              full;

   assign addr_inc = addr_q + ADDR_W'(1);
   assign empty    = (cnt_q == '0);
   assign full     = (cnt_q == CNT_W'(STACK_DEPTH));
   assign top_idx  = IDX_W'(cnt_q - CNT_W'(1));
   assign push_idx = IDX_W'(cnt_q);

`ifdef PC_TRAP_EN
   assign ovf_addr = TRAP_ADDR;
   assign unf_addr = TRAP_ADDR;
`else
   logic unused_trap;
   assign unused_trap = ^TRAP_ADDR;
   assign ovf_addr    = call_adr;
   assign unf_addr    = addr_inc;
`endif

   // One action per edge in priority order stall > ret > call > jump > branch > increment.
   always_comb begin
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      push_en = 1'b0;
      if (!stall) begin
         if (ret) begin
            if (!empty) begin
               addr_d = stack_q[top_idx];
               cnt_d  = cnt_q - CNT_W'(1);
            end else begin
               addr_d = unf_addr;
               unf_d  = 1'b1;
            end
         end else if (call) begin
            if (!full) begin
               addr_d  = call_adr;
               cnt_d   = cnt_q + CNT_W'(1);
               push_en = 1'b1;
            end else begin
               addr_d = ovf_addr;
               ovf_d  = 1'b1;
            end
         end else if (jump) begin
            addr_d = jump_adr;
         end else if (branch) begin
            addr_d = branch_adr;
         end else begin
            addr_d = addr_inc;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q <= RESET_ADDR;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
      end else begin
         addr_q <= addr_d;
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
         unf_q  <= unf_d;
      end
   end

   // Entry contents are don't-care after reset, so the storage carries no reset.
   always_ff @(posedge clk) begin
      if (push_en) begin
         stack_q[push_idx] <= addr_inc;
      end
   end

   assign address     = addr_q;
   assign stack_empty = empty;
   assign stack_full  = full;
   assign stack_ovf   = ovf_q;
   assign stack_unf   = unf_q;

endmodule

// File: tb/tb_program_counter_stack.sv
// Directed bench for program_counter_stack (ADDR_W=8, STACK_DEPTH=4) with a queue scoreboard.
module tb_program_counter_stack;

   logic       clk = 1'b0;
   logic       reset;
   logic       stall, jump, branch, call, ret;
   logic [7:0] jump_adr, branch_adr, call_adr;
   logic [7:0] address;
   logic       stack_empty, stack_full, stack_ovf, stack_unf;

   program_counter_stack #(
      .ADDR_W(8), .STACK_DEPTH(4), .RESET_ADDR(8'h00), .TRAP_ADDR(8'hFF)
   ) dut (
      .clk(clk), .reset(reset), .stall(stall),
      .jump(jump), .jump_adr(jump_adr),
      .branch(branch), .branch_adr(branch_adr),
      .call(call), .call_adr(call_adr), .ret(ret),
      .address(address), .stack_empty(stack_empty), .stack_full(stack_full),
      .stack_ovf(stack_ovf), .stack_unf(stack_unf)
   );

   always #5 clk = ~clk;

   localparam logic [4:0] NO = 5'b00000, ST = 5'b10000, RT = 5'b01000,
                          CL = 5'b00100, JP = 5'b00010, BR = 5'b00001;
`ifdef PC_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   typedef struct packed {
      logic [7:0] a;
      logic       e, f, o, u;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] m_stk[$];
   logic [7:0] m_pc;
   logic       m_ovf, m_unf;
   int         n_assert = 0;
   int         n_fail   = 0;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of controls, predict the result, then compare after the edge.
   task automatic step(input logic [4:0] ctl, input logic [7:0] ja, input logic [7:0] ba,
                       input logic [7:0] ca);
      exp_t e;
      {stall, ret, call, jump, branch} = ctl;
      jump_adr = ja; branch_adr = ba; call_adr = ca;
      if (!ctl[4]) begin
         if (ctl[3]) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin m_unf = 1'b1; m_pc = TRAP ? 8'hFF : 8'(m_pc + 8'd1); end
         end else if (ctl[2]) begin
            if (m_stk.size() < 4) begin m_stk.push_back(8'(m_pc + 8'd1)); m_pc = ca; end
            else begin m_ovf = 1'b1; m_pc = TRAP ? 8'hFF : ca; end
         end else if (ctl[1]) m_pc = ja;
         else if (ctl[0]) m_pc = ba;
         else m_pc = 8'(m_pc + 8'd1);
      end
      e.a = m_pc; e.e = (m_stk.size() == 0); e.f = (m_stk.size() == 4);
      e.o = m_ovf; e.u = m_unf;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("address", address, e.a);
      chk("stack_empty", {7'd0, stack_empty}, {7'd0, e.e});
      chk("stack_full", {7'd0, stack_full}, {7'd0, e.f});
      chk("stack_ovf", {7'd0, stack_ovf}, {7'd0, e.o});
      chk("stack_unf", {7'd0, stack_unf}, {7'd0, e.u});
   endtask

   task automatic model_reset();
      m_pc = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
      m_stk.delete();
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_address"}, address, 8'h00);
      chk({tag, "_empty"}, {7'd0, stack_empty}, 8'd1);
      chk({tag, "_full"}, {7'd0, stack_full}, 8'd0);
      chk({tag, "_ovf"}, {7'd0, stack_ovf}, 8'd0);
      chk({tag, "_unf"}, {7'd0, stack_unf}, 8'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0;
      {stall, ret, call, jump, branch} = NO;
      jump_adr = 8'h00; branch_adr = 8'h00; call_adr = 8'h00;
      model_reset();
      #22;
      chk_reset_state("reset");
      reset = 1'b1;

      // Free run after reset.
      for (int i = 0; i < 3; i++) step(NO, 8'h00, 8'h00, 8'h00);
      chk("run_0x03", address, 8'h03);

      // Jump near the top and wrap through zero.
      step(JP, 8'hFE, 8'h00, 8'h00);
      chk("jump_0xFE", address, 8'hFE);
      for (int i = 0; i < 3; i++) step(NO, 8'h00, 8'h00, 8'h00);
      chk("wrap_0x01", address, 8'h01);
      step(BR, 8'h00, 8'h80, 8'h00);
      chk("branch_0x80", address, 8'h80);

      // Nested call / return.
      step(JP, 8'h10, 8'h00, 8'h00);
      step(CL, 8'h00, 8'h00, 8'h40);
      step(NO, 8'h00, 8'h00, 8'h00);
      step(CL, 8'h00, 8'h00, 8'h60);
      chk("call_0x60", address, 8'h60);
      step(RT, 8'h00, 8'h00, 8'h00);
      chk("ret_0x42", address, 8'h42);
      step(RT, 8'h00, 8'h00, 8'h00);
      chk("ret_0x11", address, 8'h11);
      chk("ret_empty", {7'd0, stack_empty}, 8'd1);

      // Overflow then underflow.
      step(CL, 8'h00, 8'h00, 8'h20);
      step(CL, 8'h00, 8'h00, 8'h30);
      step(CL, 8'h00, 8'h00, 8'h40);
      step(CL, 8'h00, 8'h00, 8'h50);
      chk("full_after_4", {7'd0, stack_full}, 8'd1);
      step(CL, 8'h00, 8'h00, 8'h90);
      chk("ovf_address", address, TRAP ? 8'hFF : 8'h90);
      chk("ovf_flag", {7'd0, stack_ovf}, 8'd1);
      for (int i = 0; i < 4; i++) step(RT, 8'h00, 8'h00, 8'h00);
      chk("ret4_0x12", address, 8'h12);
      step(RT, 8'h00, 8'h00, 8'h00);
      chk("unf_address", address, TRAP ? 8'hFF : 8'h13);
      chk("unf_flag", {7'd0, stack_unf}, 8'd1);
      step(JP, 8'h05, 8'h00, 8'h00);
      chk("sticky_ovf", {7'd0, stack_ovf}, 8'd1);

      // Stall ignores everything; then call wins over jump and branch.
      step(CL, 8'h00, 8'h00, 8'hA0);
      step(CL, 8'h00, 8'h00, 8'hB0);
      for (int i = 0; i < 3; i++) step(ST | CL | JP, 8'h77, 8'h00, 8'h99);
      chk("stall_hold", address, 8'hB0);
      step(CL | JP | BR, 8'h07, 8'h08, 8'hC0);
      chk("prio_call", address, 8'hC0);
      step(RT, 8'h00, 8'h00, 8'h00);
      chk("prio_ret_0xB1", address, 8'hB1);
      step(RT | CL | JP, 8'h09, 8'h00, 8'h0A);
      chk("ret_over_call", address, 8'hA1);
      step(RT, 8'h00, 8'h00, 8'h00);

      // Call from all-ones pushes zero.
      step(JP, 8'hFF, 8'h00, 8'h00);
      step(CL, 8'h00, 8'h00, 8'h33);
      step(RT, 8'h00, 8'h00, 8'h00);
      chk("wrap_ret_0x00", address, 8'h00);

      // Asynchronous reset between edges while stalled with two entries.
      step(CL, 8'h00, 8'h00, 8'h55);
      step(CL, 8'h00, 8'h00, 8'h66);
      step(ST, 8'h00, 8'h00, 8'h00);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      chk_reset_state("async");
      #2;
      {stall, ret, call, jump, branch} = NO;
      reset = 1'b1;
      step(NO, 8'h00, 8'h00, 8'h00);
      chk("after_reset_0x01", address, 8'h01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
